serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes A − B LSB-first, one bit per clock, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the combinational half-adder datapath in the tiny-tapeout user project. The block trades latency for area: it latches two operands on a start pulse, streams difference bits out serially, and presents the parallel result with a final borrow and a one-cycle done strobe.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..16.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin a subtraction; sampled only in IDLE or DONE
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle strobe; diff and borrow_out are valid
- diff  output  WIDTH  (a − b) mod 2^WIDTH; holds until the next accepted start
- borrow_out  output  1  1 when a < b (unsigned); holds with diff
- dbit  output  1  current serial difference bit
- dbit_valid  output  1  high in each RUN cycle where dbit is meaningful

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- Registers: sa and sb are WIDTH-bit operand shift registers. sd is the WIDTH-bit result shift register. br is the borrow bit. cnt is a bit counter of width ceil(log2(WIDTH+1)).
- IDLE or DONE with start=1:
  - sa←a, sb←b, br←0, cnt←0, state→RUN.
  - sd is not cleared. diff and borrow_out keep their old values until the new DONE.
- IDLE with start=0: hold.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - Cell inputs: x=sa[0], y=sb[0], bin=br.
  - d = x^y^bin.
  - bnext = (~x & y) | (~(x^y) & bin).
  - sa, sb shift right by one. sd shifts right with d inserted at sd[WIDTH-1]. br←bnext. cnt←cnt+1.
  - On the edge where cnt==WIDTH−1: diff←{d, sd[WIDTH-1:1]}, borrow_out←bnext, state→DONE.
- dbit = sa[0]^sb[0]^br, computed combinationally from the current registers. dbit_valid = busy.
- start while busy (RUN) is ignored. No queueing, no error flag.
- Width rules:
  - All arithmetic is unsigned modulo 2^WIDTH.
  - Signed interpretation is left to the consumer: signed overflow = a[MSB]^b[MSB] & a[MSB]^diff[MSB], not generated here.
- Reset, asserted at any time including mid-RUN:
  - Immediately forces state=IDLE.
  - Outputs: busy=0, done=0, diff=0, borrow_out=0, dbit_valid=0, dbit=0.
  - Internal registers (sa, sb, sd, br, cnt) = 0.
  - The partial computation is discarded. The first start after deassertion begins a fresh operation.

## Timing
- Edge E0 accepts start. busy is high during cycles after E0 … E(WIDTH) edges; that is exactly WIDTH cycles.
- Serial output: bit i of the difference is on dbit during RUN cycle i (i=0 is the LSB, the first cycle after E0).
- At edge E(WIDTH): done=1, busy=0, and diff/borrow_out are updated. Latency from start sample to done is WIDTH+1 edges.
- done is high for exactly one cycle unless start is high in that DONE cycle. In that case a new RUN begins at E(WIDTH+1) and done falls.
- Throughput: back-to-back operations every WIDTH+1 cycles.
- a and b only need to be stable at the accepting edge.

## Test plan
- Reset values: assert rst for 3 cycles with random a/b/start -> busy=0, done=0, diff=0x00, borrow_out=0, dbit_valid=0 throughout.
- Basic subtraction, WIDTH=8:
  - a=0x05, b=0x03, start 1 cycle -> dbit sequence LSB-first 0,1,0,0,0,0,0,0; done 9 edges after start; diff=0x02, borrow_out=0.
  - a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
- Boundaries:
  - a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
  - a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
  - a=b=0x80 -> diff=0x00, borrow_out=0.
- Busy-ignore: start 0x10−0x01, pulse start again with a=0xAA, b=0x55 at RUN cycle 4 -> result 0x0F, borrow 0; no second done.
- Back-to-back: start held high with a=0x20, b=0x21 then a=0x40, b=0x01 at the DONE cycle -> done on edges 9 and 18; results 0xFF/1 then 0x3F/0; done low on edge 10.
- Mid-run reset: start 0x9C−0x3B, assert rst at RUN cycle 5 -> all outputs 0 immediately; after release, 0x9C−0x3B completes normally with diff=0x61, borrow_out=0.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor                                                    |
// | Bit-serial A-B, LSB first, one full-subtractor cell + borrow reg.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             dbit,
  output logic             dbit_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bnext;
  logic w_last;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_last   = (r_cnt == C_LAST);

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign w_x     = r_sa[0];
  assign w_y     = r_sb[0];
  assign w_d     = w_x ^ w_y ^ r_br;
  assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state == S_RUN);
    done       = (r_state == S_DONE);
    dbit_valid = (r_state == S_RUN);
    dbit       = w_d;
  end

  // Result registers are only touched on the final RUN edge, so diff and
  // borrow_out keep the previous answer while a new operation streams.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa       <= '0;
      r_sb       <= '0;
      r_sd       <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_sd  <= {w_d, r_sd[WIDTH-1:1]};
      r_br  <= w_bnext;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        diff       <= {w_d, r_sd[WIDTH-1:1]};
        borrow_out <= w_bnext;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_subtractor                                                 |
// | Scoreboard bench for serial_subtractor, WIDTH=8.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       dbit;
  logic       dbit_valid;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .dbit       (dbit),
    .dbit_valid (dbit_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] r;
    exp_t e;
    r    = {1'b0, av} - {1'b0, bv};
    e.d  = r[7:0];
    e.bo = r[8];
    return e;
  endfunction

  // Scoreboard side: every done pulse must match the oldest pushed result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_diff", 32'(diff), 32'(e.d));
        check_eq("sb_borrow", 32'(borrow_out), 32'(e.bo));
      end
    end
  end

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e = model(av, bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("run_busy", 32'(busy), 32'd1);
      check_eq("run_dbit_valid", 32'(dbit_valid), 32'd1);
      check_eq("run_dbit", 32'(dbit), 32'(e.d[i]));
      check_eq("run_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("done_edge", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq("done_fall", 32'(done), 32'd0);
  endtask

  initial begin
    int done_before;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); start = 1'($urandom);
      @(posedge clk); #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_diff", 32'(diff), 32'd0);
      check_eq("rst_borrow", 32'(borrow_out), 32'd0);
      check_eq("rst_dbit_valid", 32'(dbit_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    run_op(8'h05, 8'h03);
    run_op(8'h03, 8'h05);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'h00);
    run_op(8'h80, 8'h80);

    // Start pulsed mid-run must be ignored.
    done_before = n_done;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h01));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("ign_done", 32'(done), 32'd1);
    repeat (12) begin @(posedge clk); #1; end
    check_eq("ign_done_count", 32'(n_done - done_before), 32'd1);
    check_eq("ign_idle", 32'(busy), 32'd0);

    // Back-to-back with start held through the DONE cycle.
    @(negedge clk);
    a = 8'h20; b = 8'h21; start = 1'b1;
    exp_q.push_back(model(8'h20, 8'h21));
    @(posedge clk); #1;
    repeat (8) begin @(posedge clk); #1; end
    check_eq("b2b_done1", 32'(done), 32'd1);
    a = 8'h40; b = 8'h01;
    exp_q.push_back(model(8'h40, 8'h01));
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_done_fall", 32'(done), 32'd0);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_diff_hold", 32'(diff), 32'hFF);
    repeat (8) begin @(posedge clk); #1; end
    check_eq("b2b_done2", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a run.
    @(negedge clk);
    a = 8'h9C; b = 8'h3B; start = 1'b1;
    exp_q.push_back(model(8'h9C, 8'h3B));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_diff", 32'(diff), 32'd0);
    check_eq("mrst_borrow", 32'(borrow_out), 32'd0);
    check_eq("mrst_dbit_valid", 32'(dbit_valid), 32'd0);
    check_eq("mrst_dbit", 32'(dbit), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(8'h9C, 8'h3B);

    repeat (3) @(posedge clk);
    #1;
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
